// File: rtl/if_id_buffer.sv
// IF/ID instruction queue: buffers {instr, PC+2, err}, shows NOP_INSTR to decode when empty, flushable.
// Optional macro IFID_BYPASS_EN adds a zero-latency f_* -> d_* path while the queue is empty.
module if_id_buffer #(
   parameter int          DEPTH     = 2,
   parameter logic [15:0] NOP_INSTR = 16'h0800
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     f_valid,
   input  logic [15:0]              f_instr,
   input  logic [15:0]              f_pc_next,
   input  logic                     f_err,
   output logic                     f_ready,
   input  logic                     flush,
   input  logic                     d_ready,
   output logic                     d_valid,
   output logic [15:0]              d_instr,
   output logic [15:0]              d_pc_next,
   output logic                     d_err,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [15:0] instr;
      logic [15:0] pc_next;
      logic        err;
   } entry_t;

   entry_t          mem [DEPTH];
   entry_t          head;
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [CW-1:0]   cnt;
   logic            have;
   logic            bypass;
   logic            enq;
   logic            deq;

   assign have    = (cnt != '0);
   assign f_ready = (cnt < CW'(DEPTH));
   assign count   = cnt;

`ifdef IFID_BYPASS_EN
   assign bypass = !have && f_valid && !flush;
`else
   assign bypass = 1'b0;
`endif

   // A bypassed instruction that decode takes immediately never occupies a slot.
   assign enq = f_valid && f_ready && !flush && !(bypass && d_ready);
   assign deq = have && d_ready && !flush;

   always_comb begin
      head    = '{instr: NOP_INSTR, pc_next: 16'h0000, err: 1'b0};
      d_valid = 1'b0;
      if (have) begin
         head    = mem[rd_ptr];
         d_valid = 1'b1;
      end else if (bypass) begin
         head    = '{instr: f_instr, pc_next: f_pc_next, err: f_err};
         d_valid = 1'b1;
      end
   end

   assign d_instr   = head.instr;
   assign d_pc_next = head.pc_next;
   assign d_err     = head.err;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (enq) wr_ptr <= wr_ptr + PW'(1);
         if (deq) rd_ptr <= rd_ptr + PW'(1);
         case ({enq, deq})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage is not reset; occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (enq) mem[wr_ptr] <= '{instr: f_instr, pc_next: f_pc_next, err: f_err};
   end

   a_no_overflow:  assert property (@(posedge clk) disable iff (!rst) cnt <= CW'(DEPTH));
   a_no_underflow: assert property (@(posedge clk) disable iff (!rst) !(deq && !enq && cnt == '0));
endmodule

// File: tb/tb_if_id_buffer.sv
// Randomized scoreboard bench for if_id_buffer; the reference model is a plain queue of entries.
module tb_if_id_buffer;
   localparam int          DEPTH = 2;
   localparam logic [15:0] NOP   = 16'h0800;

   typedef struct packed {
      logic [15:0] instr;
      logic [15:0] pc;
      logic        err;
   } ent_t;

   logic                   clk = 1'b0;
   logic                   rst = 1'b0;
   logic                   f_valid = 1'b0;
   logic [15:0]            f_instr = '0;
   logic [15:0]            f_pc_next = '0;
   logic                   f_err = 1'b0;
   logic                   f_ready;
   logic                   flush = 1'b0;
   logic                   d_ready = 1'b0;
   logic                   d_valid;
   logic [15:0]            d_instr;
   logic [15:0]            d_pc_next;
   logic                   d_err;
   logic [$clog2(DEPTH):0] count;

   ent_t sb[$];
   int   total = 0;
   int   bad = 0;
   bit   exp_full = 1'b0;
   bit   byp_eat = 1'b0;

   if_id_buffer #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
      .clk(clk), .rst(rst),
      .f_valid(f_valid), .f_instr(f_instr), .f_pc_next(f_pc_next), .f_err(f_err),
      .f_ready(f_ready), .flush(flush), .d_ready(d_ready),
      .d_valid(d_valid), .d_instr(d_instr), .d_pc_next(d_pc_next), .d_err(d_err),
      .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compares what decode sees against the model, then retires per handshake.
   always @(negedge clk) begin
      ent_t h;
      bit   hv;
      bit   byp;
      if (rst) begin
         hv  = (sb.size() > 0);
         h   = hv ? sb[0] : '{instr: NOP, pc: 16'h0000, err: 1'b0};
         byp = 1'b0;
`ifdef IFID_BYPASS_EN
         if (!hv && f_valid && !flush) begin
            hv  = 1'b1;
            byp = 1'b1;
            h   = '{instr: f_instr, pc: f_pc_next, err: f_err};
         end
`endif
         chk("d_valid",   32'(d_valid),   32'(hv));
         chk("d_instr",   32'(d_instr),   32'(h.instr));
         chk("d_pc_next", 32'(d_pc_next), 32'(h.pc));
         chk("d_err",     32'(d_err),     32'(h.err));
         chk("count",     32'(count),     32'(sb.size()));
         chk("f_ready",   32'(f_ready),   32'(sb.size() < DEPTH));
         exp_full = (sb.size() >= DEPTH);
         byp_eat  = byp && d_ready;
         if (flush) sb.delete();
         else if (sb.size() > 0 && d_ready) void'(sb.pop_front());
      end
   end

   task automatic cyc(input bit fv, input logic [15:0] ins, input logic [15:0] pc,
                      input bit er, input bit fl, input bit dr);
      @(posedge clk);
      #1;
      f_valid = fv; f_instr = ins; f_pc_next = pc; f_err = er; flush = fl; d_ready = dr;
      @(negedge clk);
      #1;
      if (fv && !fl && !exp_full && !byp_eat) sb.push_back('{instr: ins, pc: pc, err: er});
   endtask

   task automatic drain();
      for (int i = 0; i < DEPTH + 2; i++) cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      chk("drained", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #12;
      chk("rst_d_valid", 32'(d_valid), 32'd0);
      chk("rst_d_instr", 32'(d_instr), 32'(NOP));
      chk("rst_count",   32'(count),   32'd0);
      chk("rst_f_ready", 32'(f_ready), 32'd1);
      rst = 1'b1;

      // streaming through with decode always ready
      for (int i = 1; i <= 3; i++) cyc(1'b1, 16'h4000 + 16'(i), 16'h0100 + 16'(2*i), 1'b0, 1'b0, 1'b1);
      drain();

      // fill while stalled, third push refused
      cyc(1'b1, 16'hA000, 16'h0002, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 16'hA002, 16'h0004, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 16'hA004, 16'h0006, 1'b0, 1'b0, 1'b0);
      chk("full_f_ready", 32'(f_ready), 32'd0);
      drain();

      // flush while full with a concurrent push
      cyc(1'b1, 16'hB000, 16'h0010, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 16'hB002, 16'h0012, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 16'hB004, 16'h0014, 1'b0, 1'b1, 1'b1);
      cyc(1'b1, 16'hC000, 16'h0020, 1'b1, 1'b0, 1'b0);
      drain();

      // wrap with alternating decode stalls
      for (int i = 0; i < 10; i++)
         cyc(1'b1, 16'hD000 + 16'(i), 16'h0200 + 16'(2*i), 1'(i % 3 == 0), 1'b0, 1'(i % 2));
      drain();

      // empty-buffer push with decode ready (zero latency when bypass is built in)
      cyc(1'b1, 16'h1234, 16'h5678, 1'b0, 1'b0, 1'b1);
      drain();

      // random traffic with occasional flushes and a mid-run reset
      for (int n = 0; n < 3000; n++) begin
         if (n == 1500) begin
            @(posedge clk);
            #2;
            rst = 1'b0;
            #1;
            chk("arst_d_valid", 32'(d_valid), 32'd0);
            chk("arst_d_instr", 32'(d_instr), 32'(NOP));
            chk("arst_count",   32'(count),   32'd0);
            chk("arst_f_ready", 32'(f_ready), 32'd1);
            sb.delete();
            f_valid = 1'b0;
            flush   = 1'b0;
            @(negedge clk);
            #1;
            rst = 1'b1;
         end
         cyc(1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom), 1'($urandom),
             1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)));
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
